// File: rtl/router_pkg.sv
// Shared router definitions: flit width, source-select codes and port indices.
// The transport controller uses the same codes, so change them in one place only.
package router_pkg;

    localparam int FLIT_W    = 40;
    localparam int NUM_PORTS = 3;

    // Source-select codes carried on control_*.
    localparam logic [1:0] SEL_NONE  = 2'b00;
    localparam logic [1:0] SEL_X     = 2'b01;
    localparam logic [1:0] SEL_Y     = 2'b10;
    localparam logic [1:0] SEL_LOCAL = 2'b11;

    // Bit positions of each output port in per-port vectors such as fail.
    localparam int PORT_X     = 0;
    localparam int PORT_Y     = 1;
    localparam int PORT_LOCAL = 2;

    // Number of set bits in a 3-bit per-port flag vector.
    function automatic logic [1:0] count_set3(input logic [2:0] flags);
        return {1'b0, flags[0]} + {1'b0, flags[1]} + {1'b0, flags[2]};
    endfunction

endpackage

// File: rtl/output_buffer_if.sv
// Bundle of the output buffer's flit inputs, select codes, output links and
// status. The slave side is the buffer itself; the master side is whatever
// surrounds it (transport controller upstream, next hop downstream).
interface output_buffer_if #(
    parameter int FLIT_W = router_pkg::FLIT_W,
    parameter int DROP_W = 8
);
    logic [FLIT_W-1:0] din_x, din_y, din_local;
    logic [1:0]        control_x, control_y, control_local;
    logic              out_valid_x, out_valid_y, out_valid_local;
    logic [FLIT_W-1:0] out_data_x, out_data_y, out_data_local;
    logic              out_ready_x, out_ready_y, out_ready_local;
    logic [2:0]        fail;
    logic [DROP_W-1:0] drop_cnt;

    modport slave (
        input  din_x, din_y, din_local,
        input  control_x, control_y, control_local,
        input  out_ready_x, out_ready_y, out_ready_local,
        output out_valid_x, out_valid_y, out_valid_local,
        output out_data_x, out_data_y, out_data_local,
        output fail, drop_cnt
    );

    modport master (
        output din_x, din_y, din_local,
        output control_x, control_y, control_local,
        output out_ready_x, out_ready_y, out_ready_local,
        input  out_valid_x, out_valid_y, out_valid_local,
        input  out_data_x, out_data_y, out_data_local,
        input  fail, drop_cnt
    );
endinterface

// File: rtl/flit_fifo.sv
// First-word fall-through FIFO for one output port. Writes to a full FIFO and
// reads from an empty one are ignored here; the caller counts the drops.
module flit_fifo #(
    parameter int DEPTH  = 4,
    parameter int FLIT_W = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [FLIT_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [FLIT_W-1:0] rd_data,
    output logic              empty,
    output logic              full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              wr_ok, rd_ok;

    // Full/empty come straight from the count register, so nothing an input
    // does this cycle can change them before the next edge.
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Head entry falls through; zeros when empty so stale memory never leaks.
    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

    // Storage is not reset: a zero count already marks every entry invalid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/output_buffer.sv
// Router output stage: per output port, select a source flit, queue it in a
// FIFO, present the head on a valid/ready link, and report full ports and
// rejected writes back upstream.
module output_buffer
    import router_pkg::*;
#(
    parameter int FLIT_W = router_pkg::FLIT_W,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    output_buffer_if.slave  bus
);
    localparam logic [DROP_W+1:0] DROP_MAX = {2'b00, {DROP_W{1'b1}}};

    logic [1:0]           ctrl    [NUM_PORTS];
    logic [FLIT_W-1:0]    rd_data [NUM_PORTS];
    logic [NUM_PORTS-1:0] ready, wr_req, full, empty, drops;
    logic [DROP_W-1:0]    drop_cnt_reg, drop_cnt_next;
    logic [DROP_W+1:0]    drop_sum;

    assign ctrl[PORT_X]      = bus.control_x;
    assign ctrl[PORT_Y]      = bus.control_y;
    assign ctrl[PORT_LOCAL]  = bus.control_local;
    assign ready[PORT_X]     = bus.out_ready_x;
    assign ready[PORT_Y]     = bus.out_ready_y;
    assign ready[PORT_LOCAL] = bus.out_ready_local;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : gen_port
            logic [FLIT_W-1:0] sel_flit;

            // Source mux: the select code names which input flit to enqueue.
            always_comb begin
                sel_flit = '0;
                case (ctrl[gi])
                    SEL_X:     sel_flit = bus.din_x;
                    SEL_Y:     sel_flit = bus.din_y;
                    SEL_LOCAL: sel_flit = bus.din_local;
                    default:   sel_flit = '0;
                endcase
            end

            assign wr_req[gi] = (ctrl[gi] != SEL_NONE);
            assign drops[gi]  = wr_req[gi] && full[gi];

            flit_fifo #(
                .DEPTH  (DEPTH),
                .FLIT_W (FLIT_W)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .wr_en   (wr_req[gi]),
                .wr_data (sel_flit),
                .rd_en   (ready[gi] && !empty[gi]),
                .rd_data (rd_data[gi]),
                .empty   (empty[gi]),
                .full    (full[gi])
            );
        end
    endgenerate

    assign bus.out_valid_x     = !empty[PORT_X];
    assign bus.out_valid_y     = !empty[PORT_Y];
    assign bus.out_valid_local = !empty[PORT_LOCAL];
    assign bus.out_data_x      = rd_data[PORT_X];
    assign bus.out_data_y      = rd_data[PORT_Y];
    assign bus.out_data_local  = rd_data[PORT_LOCAL];
    assign bus.fail            = full;
    assign bus.drop_cnt        = drop_cnt_reg;

    // Add this cycle's drops (0..3) with two bits of headroom, then clamp.
    always_comb begin
        drop_sum      = {2'b00, drop_cnt_reg} + {{DROP_W{1'b0}}, count_set3(drops)};
        drop_cnt_next = drop_cnt_reg;
        if (drop_sum > DROP_MAX) begin
            drop_cnt_next = {DROP_W{1'b1}};
        end else begin
            drop_cnt_next = drop_sum[DROP_W-1:0];
        end
    end

    // Saturating drop counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg <= '0;
        end else begin
            drop_cnt_reg <= drop_cnt_next;
        end
    end
endmodule

// File: tb/tb_output_buffer.sv
// Self-checking bench for output_buffer: a queue-per-port reference model is
// compared against the DUT every cycle, with directed scenarios pinned by
// literal expectations and randomized traffic in between.
module tb_output_buffer;
    import router_pkg::*;

    localparam int FW       = 40;
    localparam int DEPTH    = 4;
    localparam int DROP_W   = 8;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    bit   cmp_en = 1'b0;

    output_buffer_if #(.FLIT_W(FW), .DROP_W(DROP_W)) bus ();

    output_buffer #(.FLIT_W(FW), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    function void check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [FW-1:0] mq [3][$];
    int            m_drop = 0;

    function logic [FW-1:0] src(logic [1:0] c);
        case (c)
            2'b01:   return bus.din_x;
            2'b10:   return bus.din_y;
            2'b11:   return bus.din_local;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [1:0] c [3];
        logic       r [3];
        bit         was_full;
        if (!rst_n) begin
            for (int p = 0; p < 3; p++) mq[p].delete();
            m_drop = 0;
        end else begin
            c[0] = bus.control_x;   c[1] = bus.control_y;   c[2] = bus.control_local;
            r[0] = bus.out_ready_x; r[1] = bus.out_ready_y; r[2] = bus.out_ready_local;
            for (int p = 0; p < 3; p++) begin
                was_full = (mq[p].size() == DEPTH);
                if (c[p] != 2'b00 && was_full) m_drop++;
                if (mq[p].size() > 0 && r[p]) void'(mq[p].pop_front());
                if (c[p] != 2'b00 && !was_full) mq[p].push_back(src(c[p]));
            end
            if (m_drop > DROP_MAX) m_drop = DROP_MAX;
        end
    end

    function logic act_valid(int p);
        case (p)
            0:       return bus.out_valid_x;
            1:       return bus.out_valid_y;
            default: return bus.out_valid_local;
        endcase
    endfunction

    function logic [FW-1:0] act_data(int p);
        case (p)
            0:       return bus.out_data_x;
            1:       return bus.out_data_y;
            default: return bus.out_data_local;
        endcase
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [2:0]    exp_fail;
        logic [FW-1:0] exp_d;
        if (cmp_en && rst_n) begin
            exp_fail = '0;
            for (int p = 0; p < 3; p++) begin
                exp_d = (mq[p].size() != 0) ? mq[p][0] : '0;
                check($sformatf("valid[%0d]", p), 64'(act_valid(p)), 64'(mq[p].size() != 0));
                check($sformatf("data[%0d]", p), 64'(act_data(p)), 64'(exp_d));
                exp_fail[p] = (mq[p].size() == DEPTH);
            end
            check("fail", 64'(bus.fail), 64'(exp_fail));
            check("drop_cnt", 64'(bus.drop_cnt), 64'(m_drop));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_ctrl(logic [1:0] cx, logic [1:0] cy, logic [1:0] cl);
        bus.control_x = cx; bus.control_y = cy; bus.control_local = cl;
    endtask

    task automatic set_rdy(logic rx, logic ry, logic rl);
        bus.out_ready_x = rx; bus.out_ready_y = ry; bus.out_ready_local = rl;
    endtask

    function automatic logic [FW-1:0] rnd_flit();
        return FW'({$urandom(), $urandom()});
    endfunction

    task automatic random_cycles(int n, int ready_pct);
        for (int i = 0; i < n; i++) begin
            bus.din_x = rnd_flit(); bus.din_y = rnd_flit(); bus.din_local = rnd_flit();
            set_ctrl(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            set_rdy($urandom_range(0, 99) < ready_pct, $urandom_range(0, 99) < ready_pct,
                    $urandom_range(0, 99) < ready_pct);
            @(negedge clk);
        end
    endtask

    logic [FW-1:0] fl [6];

    initial begin
        bus.din_x = '0; bus.din_y = '0; bus.din_local = '0;
        set_ctrl(2'b00, 2'b00, 2'b00);
        set_rdy(1'b0, 1'b0, 1'b0);

        // Reset state.
        #1 rst_n = 1'b0;
        #2;
        check("rst valid", 64'({bus.out_valid_x, bus.out_valid_y, bus.out_valid_local}), 64'd0);
        check("rst data_x", 64'(bus.out_data_x), 64'd0);
        check("rst fail", 64'(bus.fail), 64'd0);
        check("rst drop", 64'(bus.drop_cnt), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        cmp_en = 1'b1;

        // Idle.
        repeat (10) @(negedge clk);
        check("idle valid", 64'({bus.out_valid_x, bus.out_valid_y, bus.out_valid_local}), 64'd0);
        check("idle fail", 64'(bus.fail), 64'd0);

        // Routing x -> y.
        bus.din_x = 40'h00_0000_00AA;
        set_ctrl(2'b00, 2'b01, 2'b00);
        set_rdy(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        set_ctrl(2'b00, 2'b00, 2'b00);
        check("route valid_y", 64'(bus.out_valid_y), 64'd1);
        check("route data_y", 64'(bus.out_data_y), 64'hAA);
        check("route others", 64'({bus.out_valid_x, bus.out_valid_local}), 64'd0);
        @(negedge clk);
        check("route drained", 64'(bus.out_valid_y), 64'd0);

        // Fill local and drop two.
        set_rdy(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            bus.din_local = rnd_flit();
            fl[i] = bus.din_local;
            set_ctrl(2'b00, 2'b00, 2'b11);
            @(negedge clk);
            if (i == 3) check("fill fail", 64'(bus.fail), 64'b100);
        end
        set_ctrl(2'b00, 2'b00, 2'b00);
        check("fill drop", 64'(bus.drop_cnt), 64'd2);
        set_rdy(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("drain order", 64'(bus.out_data_local), 64'(fl[i]));
            @(negedge clk);
        end
        check("drain empty", 64'(bus.out_valid_local), 64'd0);

        // Full with simultaneous pop on x.
        set_rdy(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bus.din_x = rnd_flit();
            set_ctrl(2'b01, 2'b00, 2'b00);
            @(negedge clk);
        end
        check("x full", 64'(bus.fail), 64'b001);
        bus.din_x = rnd_flit();
        set_rdy(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        set_ctrl(2'b00, 2'b00, 2'b00);
        check("pop-full fail", 64'(bus.fail), 64'd0);
        check("pop-full drop", 64'(bus.drop_cnt), 64'd3);
        repeat (3) @(negedge clk);
        check("pop-full count3", 64'(bus.out_valid_x), 64'd0);

        // Broadcast of din_y across pointer wrap.
        set_rdy(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            bus.din_y = rnd_flit();
            set_ctrl(2'b10, 2'b10, 2'b10);
            @(negedge clk);
            check("bcast x", 64'(bus.out_data_x), 64'(bus.din_y));
            check("bcast local", 64'(bus.out_data_local), 64'(bus.din_y));
        end
        set_ctrl(2'b00, 2'b00, 2'b00);
        @(negedge clk);
        check("bcast drop", 64'(bus.drop_cnt), 64'd3);

        // Random mixed traffic.
        random_cycles(400, 50);

        // Async reset with two entries per port.
        set_ctrl(2'b00, 2'b00, 2'b00);
        set_rdy(1'b1, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        set_rdy(1'b0, 1'b0, 1'b0);
        repeat (2) begin
            bus.din_x = rnd_flit();
            set_ctrl(2'b01, 2'b01, 2'b01);
            @(negedge clk);
        end
        set_ctrl(2'b00, 2'b00, 2'b00);
        check("pre-rst valid", 64'({bus.out_valid_x, bus.out_valid_y, bus.out_valid_local}), 64'b111);
        #2 rst_n = 1'b0;
        #1;
        check("async valid", 64'({bus.out_valid_x, bus.out_valid_y, bus.out_valid_local}), 64'd0);
        check("async fail", 64'(bus.fail), 64'd0);
        check("async data_y", 64'(bus.out_data_y), 64'd0);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post-rst empty", 64'({bus.out_valid_x, bus.out_valid_y, bus.out_valid_local}), 64'd0);

        // Drive the drop counter into saturation.
        set_rdy(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 120; i++) begin
            bus.din_x = rnd_flit(); bus.din_y = rnd_flit(); bus.din_local = rnd_flit();
            set_ctrl(2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)));
            @(negedge clk);
        end
        check("drop saturated", 64'(bus.drop_cnt), 64'(DROP_MAX));
        random_cycles(200, 60);

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/output_buffer.md
# output_buffer

Output stage of the 3-port router (x, y, local), directly downstream of the transport controller. Each cycle it uses the per-output 2-bit select codes to pick one of the three 40-bit input flits per output port and writes it into that port's FIFO. It presents each FIFO on a valid/ready link to the next hop, and returns a per-port `fail` (FIFO full) vector upstream so the transport controller stops steering into a full port.

## Interface
- `FLIT_W`, 40, flit width in bits
- `DEPTH`, 4, entries per output FIFO; power of two, ≥2
- `DROP_W`, 8, width of the saturating drop counter

- `clk` input 1: single clock, rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `din_x`, `din_y`, `din_local` input `FLIT_W` each: input-port flits
- `control_x`, `control_y`, `control_local` input 2 each: source select per output. 00 = none, 01 = `din_x`, 10 = `din_y`, 11 = `din_local`.
- `out_valid_x`, `out_valid_y`, `out_valid_local` output 1 each: head flit available
- `out_data_x`, `out_data_y`, `out_data_local` output `FLIT_W` each: head flit; all-zero when the FIFO is empty
- `out_ready_x`, `out_ready_y`, `out_ready_local` input 1 each: downstream accepts the head flit
- `fail` output 3: FIFO full flags. Bit 0 = x, bit 1 = y, bit 2 = local.
- `drop_cnt` output `DROP_W`: saturating count of rejected writes

## Operation
- Write request for port p: `control_p != 2'b00`. Data source is the flit named by the code.
- A write is accepted only when FIFO p is not full at the start of the cycle. It stores the flit at `wr_ptr_p`, then increments `wr_ptr_p` and `count_p`.
- A write request to a full FIFO is dropped, and `drop_cnt` is incremented.
  - Multiple drops in one cycle (up to 3) add their total.
  - `drop_cnt` saturates at 2^DROP_W−1; it does not wrap.
- Read: the pop happens when `out_valid_p && out_ready_p`, advancing `rd_ptr_p` and decrementing `count_p`. `out_ready_p` while empty has no effect.
- Simultaneous accepted write and pop: `count_p` is unchanged and both pointers advance.
- Full and pop in the same cycle: only the pop takes effect. The write is dropped, because `fail` was already asserted to upstream.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `count_p` is `$clog2(DEPTH+1)` bits, range 0..DEPTH.
- `out_valid_p = (count_p != 0)`.
- `fail[p] = (count_p == DEPTH)`. It is decoded from registers only, so there is no combinational path from any input to `fail`.
- The three ports are independent. The same input flit may be written to several ports in one cycle if several selects name it.

## Timing
- Reset (async assert, sync release): all pointers and counts go to 0. `out_valid_*` = 0, `out_data_*` = 0, `fail` = 3'b000, `drop_cnt` = 0. Memory contents are not reset.
- A reset asserted mid-operation discards all stored flits immediately, and outputs take their reset values without waiting for a clock.
- Write latency: a flit written at edge N is on `out_data_p`, with `out_valid_p` = 1, after edge N (first-word fall-through, 1 cycle).
- Pop: the head flit is consumed at the edge where valid && ready. The next entry, or zeros, appears after that edge.
- `fail[p]` rises after the edge that makes the FIFO full, and falls after the edge of the first pop from full.
- `drop_cnt` updates at the edge of the rejected request.

## Structure
- Shared package `router_pkg`:
  - `FLIT_W`
  - select-code constants `SEL_NONE`=2'b00, `SEL_X`=2'b01, `SEL_Y`=2'b10, `SEL_LOCAL`=2'b11
  - port index constants `PORT_X`=0, `PORT_Y`=1, `PORT_LOCAL`=2
  - these are the same codes the transport controller emits and consumes
- One sub-module, `flit_fifo`:
  - parameters DEPTH and FLIT_W
  - ports `wr_en`, `wr_data`, `rd_en`, `rd_data`, `empty`, `full`
  - instantiated three times
- Top level holds the source muxes, the handshake glue, and the drop counter.

## Test plan
- Reset then idle: all outputs zero; release reset; `control_*`=00 for 10 cycles -> `out_valid_*`=0, `fail`=000, `drop_cnt`=0.
- Routing: `control_y`=01 with `din_x`=40'h00_0000_00AA for one cycle, `out_ready_y`=1 -> `out_valid_y`=1 with `out_data_y`=40'hAA on the next cycle, then empty. Ports x and local stay empty.
- Fill and drop: `control_local`=11 for 6 consecutive cycles with DEPTH=4 and `out_ready_local`=0 -> `fail`=3'b100 after the 4th write, `drop_cnt`=2. The 4 stored flits drain in order once `out_ready_local`=1.
- Full with simultaneous pop: port x full, `control_x`=01 and `out_ready_x`=1 in the same cycle -> count becomes 3, `fail[0]` drops to 0, `drop_cnt` increments by 1.
- Broadcast and wrap: `control_x`=`control_y`=`control_local`=10 for 9 cycles with all readies high -> each port outputs the 9 `din_y` flits in order across pointer wrap, with no drops.
- Async reset mid-traffic: assert `rst_n`=0 with all FIFOs holding 2 entries -> `out_valid_*`=0 and `fail`=000 before the next clock edge. After release, the FIFOs are empty.
